// File: rtl/digit_entry_ctrl.sv
// Front-panel digit entry: buttons edit an 8x4-bit shadow and cursor, then hand the value to the counter over req/ack and gate its run enable.
// Outputs are registered state or a mux of registers; load_req stays high until load_ack, with no timeout.
module digit_entry_ctrl #(
    parameter int unsigned DIGIT_MAX = 9,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_load,
    input  logic        load_ack,
    output logic [2:0]  bitSW,
    output logic [3:0]  digitSW,
    output logic [31:0] load_value,
    output logic        load_req,
    output logic        run_en,
    output logic        blink,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_EDIT   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    localparam int unsigned     CNT_W    = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [3:0]      DIG_MAX  = 4'(DIGIT_MAX);

    state_t             state_q, state_d;
    logic [2:0]         cursor_q, cursor_d;
    logic [31:0]        shadow_q, shadow_d;
    logic               blink_q, blink_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         cur_dig, new_dig;
    logic               edit_ok;

    assign cur_dig = shadow_q[{cursor_q, 2'b00} +: 4];

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        shadow_d = shadow_q;
        blink_d  = blink_q;
        cnt_d    = cnt_q;
        new_dig  = cur_dig;
        edit_ok  = 1'b0;

        // A commit press suppresses same-cycle edits so load_value is exactly the shadow seen at that edge.
        case (state_q)
            ST_EDIT: begin
                if (btn_load) state_d = ST_COMMIT;
                else          edit_ok = 1'b1;
            end
            ST_COMMIT: if (load_ack) state_d = ST_RUN;
            ST_RUN:    if (btn_load) state_d = ST_EDIT;
            default:   state_d = ST_EDIT;
        endcase

        if (edit_ok) begin
            if (btn_up && btn_down) new_dig = 4'd0;
            else if (btn_up)        new_dig = (cur_dig >= DIG_MAX) ? 4'd0 : cur_dig + 4'd1;
            else if (btn_down)      new_dig = (cur_dig == 4'd0) ? DIG_MAX : cur_dig - 4'd1;
            shadow_d[{cursor_q, 2'b00} +: 4] = new_dig;

            if (btn_left && !btn_right)      cursor_d = cursor_q + 3'd1;
            else if (btn_right && !btn_left) cursor_d = cursor_q - 3'd1;
        end

        if (state_q == ST_EDIT && state_d == ST_EDIT) begin
            if (cursor_d != cursor_q || new_dig != cur_dig) begin
                cnt_d   = '0;
                blink_d = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                blink_d = ~blink_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d   = '0;
            blink_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_EDIT;
            cursor_q <= 3'd0;
            shadow_q <= 32'd0;
            blink_q  <= 1'b1;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            shadow_q <= shadow_d;
            blink_q  <= blink_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bitSW      = cursor_q;
    assign digitSW    = cur_dig;
    assign load_value = shadow_q;
    assign load_req   = (state_q == ST_COMMIT);
    assign run_en     = (state_q == ST_RUN);
    assign blink      = blink_q;
    assign state      = state_q;

endmodule
